bcd_donusturucu: RTL and testbench

BCD_DONUSTURUCU -- requirements
Module: bcd_donusturucu

---
 rtl/bcd_donusturucu_pkg.sv | 42 ++++
 rtl/bcd_add3.sv | 15 +
 rtl/bcd_donusturucu.sv | 145 ++++++++++++++
 tb/tb_bcd_donusturucu.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_donusturucu_pkg.sv
// rtl/bcd_donusturucu_pkg.sv - shared constants, FSM encoding and blank-mask helper
//
// Contents:
//   GIRIS_W       width of the binary input (32)
//   BASAMAK       number of BCD digits (10)
//   SONUC_W       packed BCD result width (40)
//   SAYAC_W       iteration counter width
//   SON_ADIM      counter value of the final shift cycle
//   TASMA_DESENI  result pattern shown on upstream overflow (all F)
//   durum_t       FSM states BOSTA / KAYDIR / BITTI
//   bos_maskesi() leading-zero blank mask of a packed BCD value
package bcd_donusturucu_pkg;

    localparam int GIRIS_W  = 32;
    localparam int BASAMAK  = 10;
    localparam int SONUC_W  = 4 * BASAMAK;
    localparam int SAYAC_W  = $clog2(GIRIS_W);

    localparam logic [SAYAC_W-1:0] SON_ADIM     = SAYAC_W'(GIRIS_W - 1);
    localparam logic [SONUC_W-1:0] TASMA_DESENI = {SONUC_W{1'b1}};

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        KAYDIR = 2'd1,
        BITTI  = 2'd2
    } durum_t;

    // Digit i (i >= 1) is blanked when it and every higher digit are zero.
    // Digit 0 is never blanked so a zero value still shows a single "0".
    function automatic logic [BASAMAK-1:0] bos_maskesi(input logic [SONUC_W-1:0] bcd);
        logic [BASAMAK-1:0] maske;
        logic               ust_sifir;
        maske     = '0;
        ust_sifir = 1'b1;
        for (int i = BASAMAK - 1; i >= 1; i--) begin
            ust_sifir = ust_sifir & (bcd[4*i +: 4] == 4'd0);
            maske[i]  = ust_sifir;
        end
        return maske;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble per-digit conditional add-3
//
// Ports:
//   basamak_in   [3:0]  scratch BCD digit before correction
//   basamak_out  [3:0]  digit + 3 when digit >= 5, else unchanged
module bcd_add3 (
    input  logic [3:0] basamak_in,
    output logic [3:0] basamak_out
);

    // A digit >= 5 would become >= 10 after the following left shift;
    // adding 3 first makes that shift carry cleanly into the next digit.
    assign basamak_out = (basamak_in >= 4'd5) ? (basamak_in + 4'd3) : basamak_in;

endmodule

// File: rtl/bcd_donusturucu.sv
// rtl/bcd_donusturucu.sv - 32-bit binary to 10-digit packed BCD converter (shift-add-3)
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous active-high reset
//   sayi     in   32  unsigned binary input
//   gecerli  in   1   input strobe, sayi/tasma valid this cycle
//   tasma    in   1   upstream overflow flag, sampled with gecerli
//   sonuc    out  40  packed BCD result, [3:0] = units
//   bos      out  10  per-digit blank mask for the display driver
//   hazir    out  1   one-cycle pulse: sonuc/bos/hata updated
//   mesgul   out  1   conversion in progress, new strobes are ignored
//   hata     out  1   last accepted input carried tasma
//
// Build option: LEADING_ZERO_BLANK_EN enables leading-zero blanking on bos;
// without it bos is tied to zero.
module bcd_donusturucu
    import bcd_donusturucu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  sayi,
    input  logic         gecerli,
    input  logic         tasma,
    output logic [39:0]  sonuc,
    output logic [9:0]   bos,
    output logic         hazir,
    output logic         mesgul,
    output logic         hata
);

    durum_t               durum;
    durum_t               sonraki_durum;
    logic [GIRIS_W-1:0]   kaydirici;
    logic [SONUC_W-1:0]   karalama;
    logic [SAYAC_W-1:0]   sayac;
    logic [SONUC_W-1:0]   sonuc_r;
    logic                 hata_r;

    logic [SONUC_W-1:0]   duzeltilmis;
    logic [SONUC_W-1:0]   yeni_karalama;
    logic [GIRIS_W-1:0]   yeni_kaydirici;

    // Ten parallel add-3 correctors, one per scratch digit.
    for (genvar g = 0; g < BASAMAK; g++) begin : g_add3
        bcd_add3 u_add3 (
            .basamak_in  (karalama[4*g +: 4]),
            .basamak_out (duzeltilmis[4*g +: 4])
        );
    end

    // {scratch, shift} shifted left by one after correction.
    assign yeni_karalama  = {duzeltilmis[SONUC_W-2:0], kaydirici[GIRIS_W-1]};
    assign yeni_kaydirici = {kaydirici[GIRIS_W-2:0], 1'b0};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            durum <= BOSTA;
        end else begin
            durum <= sonraki_durum;
        end
    end

    // Next-state logic.
    always_comb begin
        sonraki_durum = durum;
        case (durum)
            BOSTA: begin
                if (gecerli) begin
                    sonraki_durum = tasma ? BITTI : KAYDIR;
                end
            end
            KAYDIR: begin
                if (sayac == SON_ADIM) begin
                    sonraki_durum = BITTI;
                end
            end
            BITTI:   sonraki_durum = BOSTA;
            default: sonraki_durum = BOSTA;
        endcase
    end

    // Output logic.
    always_comb begin
        hazir  = (durum == BITTI);
        mesgul = (durum != BOSTA);
    end

    // Datapath: load, iterate, and capture the result on the last shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            kaydirici <= '0;
            karalama  <= '0;
            sayac     <= '0;
            sonuc_r   <= '0;
            hata_r    <= 1'b0;
        end else begin
            case (durum)
                BOSTA: begin
                    if (gecerli && !tasma) begin
                        kaydirici <= sayi;
                        karalama  <= '0;
                        sayac     <= '0;
                    end else if (gecerli && tasma) begin
                        sonuc_r <= TASMA_DESENI;
                        hata_r  <= 1'b1;
                    end
                end
                KAYDIR: begin
                    kaydirici <= yeni_kaydirici;
                    karalama  <= yeni_karalama;
                    sayac     <= sayac + 1'b1;
                    if (sayac == SON_ADIM) begin
                        sonuc_r <= yeni_karalama;
                        hata_r  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sonuc = sonuc_r;
    assign hata  = hata_r;

`ifdef LEADING_ZERO_BLANK_EN
    logic [BASAMAK-1:0] bos_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            bos_r <= '0;
        end else if (durum == BOSTA && gecerli && tasma) begin
            bos_r <= '0;
        end else if (durum == KAYDIR && sayac == SON_ADIM) begin
            bos_r <= bos_maskesi(yeni_karalama);
        end
    end

    assign bos = bos_r;
`else
    assign bos = '0;
`endif

endmodule

// File: tb/tb_bcd_donusturucu.sv
// tb/tb_bcd_donusturucu.sv - scoreboard bench for bcd_donusturucu
module tb_bcd_donusturucu;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  sayi;
    logic         gecerli;
    logic         tasma;
    logic [39:0]  sonuc;
    logic [9:0]   bos;
    logic         hazir;
    logic         mesgul;
    logic         hata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [39:0] s;
        logic [9:0]  b;
        logic        h;
        int          acc;
        int          lat;
    } beklenen_t;

    beklenen_t q[$];
    beklenen_t mon_e;

    bcd_donusturucu dut (
        .clk     (clk),
        .rst     (rst),
        .sayi    (sayi),
        .gecerli (gecerli),
        .tasma   (tasma),
        .sonuc   (sonuc),
        .bos     (bos),
        .hazir   (hazir),
        .mesgul  (mesgul),
        .hata    (hata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cyc %0d)", n, a, e, cyc);
        end
    endtask

    // Monitor: every hazir pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (hazir === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hazir actual=1 expected=0 sonuc=%h cyc=%0d", sonuc, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("sonuc",   64'(sonuc), 64'(mon_e.s));
                chk("bos",     64'(bos),   64'(mon_e.b));
                chk("hata",    64'(hata),  64'(mon_e.h));
                chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
            end
        end
    end

    // Drive one strobe; when push is set, queue the expected response.
    // bm is the blank mask expected when blanking is built in.
    task automatic issue(input logic [31:0] s, input logic t, input logic push,
                         input logic [39:0] es, input logic [9:0] bm);
        beklenen_t e;
        @(negedge clk);
        sayi    = s;
        tasma   = t;
        gecerli = 1'b1;
        if (push) begin
            e.s   = es;
`ifdef LEADING_ZERO_BLANK_EN
            e.b   = bm;
`else
            e.b   = 10'd0;
`endif
            e.h   = t;
            e.acc = cyc;
            e.lat = t ? 1 : 33;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        gecerli = 1'b0;
        tasma   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL hazir_timeout actual=%0d expected=0 pending", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_idle(input string n);
        chk({n, "_sonuc"},  64'(sonuc),  64'd0);
        chk({n, "_bos"},    64'(bos),    64'd0);
        chk({n, "_hazir"},  64'(hazir),  64'd0);
        chk({n, "_mesgul"}, 64'(mesgul), 64'd0);
        chk({n, "_hata"},   64'(hata),   64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        sayi    = '0;
        gecerli = 1'b0;
        tasma   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        issue(32'd0,          1'b0, 1'b1, 40'h0000000000, 10'b1111111110);
        drain();
        issue(32'd12345,      1'b0, 1'b1, 40'h0000012345, 10'b1111100000);
        drain();
        issue(32'd9,          1'b0, 1'b1, 40'h0000000009, 10'b1111111110);
        drain();
        issue(32'd10,         1'b0, 1'b1, 40'h0000000010, 10'b1111111100);
        drain();
        issue(32'd1000000000, 1'b0, 1'b1, 40'h1000000000, 10'b0000000000);
        drain();
        issue(32'hFFFFFFFF,   1'b0, 1'b1, 40'h4294967295, 10'b0000000000);
        drain();

        // Results hold between pulses.
        repeat (5) @(negedge clk);
        chk("hold_sonuc", 64'(sonuc), 64'h4294967295);
        chk("hold_hata",  64'(hata),  64'd0);

        // Overflow short path.
        issue(32'd7, 1'b1, 1'b1, 40'hFFFFFFFFFF, 10'b0000000000);
        drain();

        // Second strobe while busy is ignored.
        issue(32'd100, 1'b0, 1'b1, 40'h0000000100, 10'b1111111000);
        repeat (9) @(negedge clk);
        chk("busy_mesgul", 64'(mesgul), 64'd1);
        sayi    = 32'd5;
        gecerli = 1'b1;
        @(posedge clk);
        #1;
        gecerli = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        chk("ignored_sonuc", 64'(sonuc), 64'h0000000100);

        // Reset mid-conversion discards the result.
        issue(32'd999, 1'b0, 1'b0, 40'h0, 10'b0);
        repeat (14) @(negedge clk);
        chk("mid_mesgul", 64'(mesgul), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("midrst");
        repeat (40) @(negedge clk);
        issue(32'd42, 1'b0, 1'b1, 40'h0000000042, 10'b1111111100);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
